// File: rtl/int_to_int_wb.sv
// Writeback collector behind the INT-to-INT converter: stages beats, merges 16b low/high halves
// (when INTTOINT_WB_MERGE_EN is defined) and queues writes for the register file.
//
// state    | meaning
// ST_EMPTY | stage register holds nothing
// ST_HOLD  | stage holds a non-candidate beat, pushed next cycle
// ST_WAIT  | stage holds a 16b low half waiting for its high-half partner
module int_to_int_wb #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [127:0]             dr_inttoint_d_in,
    input  logic [6:0]               cru_inttoint_in,
    input  logic [4:0]               smc_id_in,
    input  logic                     wb_rdy,
    output logic                     wb_vld,
    output logic [127:0]             wb_data,
    output logic [15:0]              wb_mask,
    output logic [4:0]               wb_id,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     ovf_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_WAIT} state_t;

    state_t         state, state_nxt;
    logic [127:0]   s_data;
    logic [15:0]    s_mask;
    logic [4:0]     s_id;

    logic           beat, prec, pos, beat_cand;
    logic [3:0]     lane_mask;
    logic [15:0]    beat_mask;
    logic           load, push;
    logic [127:0]   push_data;
    logic [15:0]    push_mask;
    logic [4:0]     push_id;

    logic [127:0]   mem_data [DEPTH];
    logic [15:0]    mem_mask [DEPTH];
    logic [4:0]     mem_id   [DEPTH];
    logic [AW-1:0]  head, tail;
    logic [AW:0]    cnt;
    logic           full, pop, wr, drop;

    logic           unused_cru;
    assign unused_cru = ^{cru_inttoint_in[5], cru_inttoint_in[3:1]};

    assign beat      = cru_inttoint_in[6];
    assign prec      = cru_inttoint_in[4];
    assign pos       = cru_inttoint_in[0];
    assign lane_mask = prec ? 4'hF : (pos ? 4'hC : 4'h3);
    assign beat_mask = {4{lane_mask}};

`ifdef INTTOINT_WB_MERGE_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0]  idle_cnt;
    logic           idle_inc;
    logic           beat_match;
    logic [127:0]   merged;

    assign beat_cand  = beat & ~prec & ~pos;
    assign beat_match = beat & ~prec & pos & (smc_id_in == s_id);

    // Upper 16 bits of every lane from the high-half beat, lower 16 from the stage.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[32*i +: 32] = {dr_inttoint_d_in[32*i+16 +: 16], s_data[32*i +: 16]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !idle_inc) idle_cnt <= '0;
        else                  idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic           unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign beat_cand      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        push      = 1'b0;
        push_data = s_data;
        push_mask = s_mask;
        push_id   = s_id;
`ifdef INTTOINT_WB_MERGE_EN
        idle_inc  = 1'b0;
`endif
        case (state)
            ST_EMPTY: begin
                if (beat) begin
                    load      = 1'b1;
                    state_nxt = beat_cand ? ST_WAIT : ST_HOLD;
                end
            end
            ST_HOLD: begin
                push = 1'b1;
                if (beat) begin
                    load      = 1'b1;
                    state_nxt = beat_cand ? ST_WAIT : ST_HOLD;
                end else begin
                    state_nxt = ST_EMPTY;
                end
            end
`ifdef INTTOINT_WB_MERGE_EN
            ST_WAIT: begin
                if (beat_match) begin
                    push      = 1'b1;
                    push_data = merged;
                    push_mask = 16'hFFFF;
                    state_nxt = ST_EMPTY;
                end else if (beat) begin
                    push      = 1'b1;
                    load      = 1'b1;
                    state_nxt = beat_cand ? ST_WAIT : ST_HOLD;
                end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                    push      = 1'b1;
                    state_nxt = ST_EMPTY;
                end else begin
                    idle_inc  = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            s_data <= '0;
            s_mask <= '0;
            s_id   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                s_data <= dr_inttoint_d_in;
                s_mask <= beat_mask;
                s_id   <= smc_id_in;
            end
        end
    end

    // The converter cannot stall, so a push into a full FIFO without a pop is dropped.
    assign full = (cnt == (AW+1)'(DEPTH));
    assign pop  = (cnt != '0) && wb_rdy;
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            ovf_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_mask[i] <= '0;
                mem_id[i]   <= '0;
            end
        end else begin
            if (wr) begin
                mem_data[tail] <= push_data;
                mem_mask[tail] <= push_mask;
                mem_id[tail]   <= push_id;
                tail           <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            if (wr && !pop)      cnt <= cnt + 1'b1;
            else if (!wr && pop) cnt <= cnt - 1'b1;
            if (drop) ovf_err <= 1'b1;
        end
    end

    assign wb_vld   = (cnt != '0);
    assign wb_data  = mem_data[head];
    assign wb_mask  = mem_mask[head];
    assign wb_id    = mem_id[head];
    assign fifo_cnt = cnt;

endmodule

// File: tb/tb_int_to_int_wb.sv
// Directed self-checking bench for int_to_int_wb; expectations follow INTTOINT_WB_MERGE_EN.
module tb_int_to_int_wb;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam logic [6:0] C32  = 7'b1010000;
    localparam logic [6:0] C16L = 7'b1000000;
    localparam logic [6:0] C16H = 7'b1000001;

    logic           clk = 1'b0;
    logic           rst;
    logic [127:0]   d_in;
    logic [6:0]     cru;
    logic [4:0]     smc_id;
    logic           wb_rdy;
    logic           wb_vld;
    logic [127:0]   wb_data;
    logic [15:0]    wb_mask;
    logic [4:0]     wb_id;
    logic [2:0]     fifo_cnt;
    logic           ovf_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int_to_int_wb #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .dr_inttoint_d_in (d_in),
        .cru_inttoint_in  (cru),
        .smc_id_in        (smc_id),
        .wb_rdy           (wb_rdy),
        .wb_vld           (wb_vld),
        .wb_data          (wb_data),
        .wb_mask          (wb_mask),
        .wb_id            (wb_id),
        .fifo_cnt         (fifo_cnt),
        .ovf_err          (ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rep(input logic [31:0] w);
        return {4{w}};
    endfunction

    task automatic drive(input logic [127:0] d, input logic [6:0] c, input logic [4:0] id);
        d_in   = d;
        cru    = c;
        smc_id = id;
    endtask

    task automatic idle();
        drive('0, 7'b0, 5'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        wb_rdy = 1'b1;
        drive(rep(32'h5555_5555), C32, 5'd7);
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({wb_vld, wb_data, wb_mask, wb_id, fifo_cnt, ovf_err} !== '0) begin
            $display("FAIL reset_outputs: got vld=%0b data=%h mask=%h id=%0d cnt=%0d ovf=%0b, expected all zero",
                     wb_vld, wb_data, wb_mask, wb_id, fifo_cnt, ovf_err);
        end else pass_cnt++;
        rst    = 1'b0;
        wb_rdy = 1'b0;
        drive({32{4'h1}}, C32, 5'd9);
        @(negedge clk);
        idle();
        total_cnt++;
        if (wb_vld !== 1'b0) $display("FAIL first_beat_early: got vld=%0b expected 0", wb_vld);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wb_vld !== 1'b1 || wb_mask !== 16'hFFFF || wb_data !== {32{4'h1}} || wb_id !== 5'd9 || fifo_cnt !== 3'd1)
            $display("FAIL first_beat: got vld=%0b mask=%h data=%h id=%0d cnt=%0d expected 1 ffff %h 9 1",
                     wb_vld, wb_mask, wb_data, wb_id, fifo_cnt, {32{4'h1}});
        else pass_cnt++;
        wb_rdy = 1'b1;
        @(negedge clk);
        wb_rdy = 1'b0;
        total_cnt++;
        if (fifo_cnt !== 3'd0 || wb_vld !== 1'b0) $display("FAIL first_pop: got cnt=%0d expected 0", fifo_cnt);
        else pass_cnt++;
    endtask

    task automatic test_merge();
        reset_dut();
        wb_rdy = 1'b0;
        drive(rep(32'h0000_AAAA), C16L, 5'd3);
        @(negedge clk);
        drive(rep(32'hBBBB_0000), C16H, 5'd3);
        @(negedge clk);
        idle();
`ifdef INTTOINT_WB_MERGE_EN
        total_cnt++;
        if (fifo_cnt !== 3'd1 || wb_data !== rep(32'hBBBB_AAAA) || wb_mask !== 16'hFFFF || wb_id !== 5'd3)
            $display("FAIL merge_entry: got cnt=%0d data=%h mask=%h id=%0d expected 1 %h ffff 3",
                     fifo_cnt, wb_data, wb_mask, wb_id, rep(32'hBBBB_AAAA));
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (fifo_cnt !== 3'd1) $display("FAIL merge_single: got cnt=%0d expected 1", fifo_cnt);
        else pass_cnt++;
`else
        total_cnt++;
        if (fifo_cnt !== 3'd1 || wb_data !== rep(32'h0000_AAAA) || wb_mask !== 16'h3333 || wb_id !== 5'd3)
            $display("FAIL nomerge_low: got cnt=%0d data=%h mask=%h id=%0d expected 1 %h 3333 3",
                     fifo_cnt, wb_data, wb_mask, wb_id, rep(32'h0000_AAAA));
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (fifo_cnt !== 3'd2) $display("FAIL nomerge_count: got cnt=%0d expected 2", fifo_cnt);
        else pass_cnt++;
        wb_rdy = 1'b1;
        @(negedge clk);
        wb_rdy = 1'b0;
        total_cnt++;
        if (wb_data !== rep(32'hBBBB_0000) || wb_mask !== 16'hCCCC || wb_id !== 5'd3)
            $display("FAIL nomerge_high: got data=%h mask=%h id=%0d expected %h cccc 3",
                     wb_data, wb_mask, wb_id, rep(32'hBBBB_0000));
        else pass_cnt++;
`endif
    endtask

    task automatic test_mismatch();
        reset_dut();
        wb_rdy = 1'b0;
        drive(rep(32'h0000_1234), C16L, 5'd3);
        @(negedge clk);
        drive(rep(32'h5678_0000), C16H, 5'd4);
        @(negedge clk);
        idle();
        @(negedge clk);
        total_cnt++;
        if (fifo_cnt !== 3'd2 || wb_mask !== 16'h3333 || wb_id !== 5'd3 || wb_data !== rep(32'h0000_1234))
            $display("FAIL mismatch_first: got cnt=%0d mask=%h id=%0d data=%h expected 2 3333 3 %h",
                     fifo_cnt, wb_mask, wb_id, wb_data, rep(32'h0000_1234));
        else pass_cnt++;
        wb_rdy = 1'b1;
        @(negedge clk);
        wb_rdy = 1'b0;
        total_cnt++;
        if (wb_mask !== 16'hCCCC || wb_id !== 5'd4 || wb_data !== rep(32'h5678_0000))
            $display("FAIL mismatch_second: got mask=%h id=%0d data=%h expected cccc 4 %h",
                     wb_mask, wb_id, wb_data, rep(32'h5678_0000));
        else pass_cnt++;
    endtask

`ifdef INTTOINT_WB_MERGE_EN
    task automatic test_timeout();
        logic early;
        reset_dut();
        wb_rdy = 1'b0;
        early  = 1'b0;
        drive(rep(32'h0000_7777), C16L, 5'd5);
        @(negedge clk);
        idle();
        for (int k = 1; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (wb_vld !== 1'b0) early = 1'b1;
        end
        total_cnt++;
        if (early !== 1'b0) $display("FAIL timeout_early: got early push=%0b expected 0", early);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wb_vld !== 1'b1 || wb_mask !== 16'h3333 || wb_id !== 5'd5)
            $display("FAIL timeout_push: got vld=%0b mask=%h id=%0d expected 1 3333 5", wb_vld, wb_mask, wb_id);
        else pass_cnt++;
    endtask
`endif

    task automatic test_overflow();
        reset_dut();
        wb_rdy = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(rep(32'h1000_0000 + i), C32, 5'(i + 1));
            @(negedge clk);
            if (i == DEPTH) begin
                total_cnt++;
                if (fifo_cnt !== 3'(DEPTH) || ovf_err !== 1'b0)
                    $display("FAIL ovf_full: got cnt=%0d ovf=%0b expected %0d 0", fifo_cnt, ovf_err, DEPTH);
                else pass_cnt++;
            end
        end
        idle();
        total_cnt++;
        if (ovf_err !== 1'b1 || fifo_cnt !== 3'(DEPTH))
            $display("FAIL ovf_set: got ovf=%0b cnt=%0d expected 1 %0d", ovf_err, fifo_cnt, DEPTH);
        else pass_cnt++;
        @(negedge clk);
        wb_rdy = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            total_cnt++;
            if (wb_id !== 5'(j + 1) || wb_data !== rep(32'h1000_0000 + j))
                $display("FAIL ovf_drain_%0d: got id=%0d data=%h expected %0d %h",
                         j, wb_id, wb_data, j + 1, rep(32'h1000_0000 + j));
            else pass_cnt++;
            @(negedge clk);
        end
        wb_rdy = 1'b0;
        total_cnt++;
        if (fifo_cnt !== 3'd0 || ovf_err !== 1'b1)
            $display("FAIL ovf_sticky: got cnt=%0d ovf=%0b expected 0 1", fifo_cnt, ovf_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        reset_dut();
        wb_rdy = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            drive(rep(32'h2000_0000 + i), C32, 5'(i));
            @(negedge clk);
        end
        total_cnt++;
        if (fifo_cnt !== 3'(DEPTH)) $display("FAIL b2b_fill: got cnt=%0d expected %0d", fifo_cnt, DEPTH);
        else pass_cnt++;
        wb_rdy = 1'b1;
        drive(rep(32'h2000_0006), C32, 5'd6);
        @(negedge clk);
        idle();
        total_cnt++;
        if (fifo_cnt !== 3'(DEPTH) || ovf_err !== 1'b0 || wb_id !== 5'd2)
            $display("FAIL b2b_pushpop1: got cnt=%0d ovf=%0b id=%0d expected %0d 0 2", fifo_cnt, ovf_err, wb_id, DEPTH);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (fifo_cnt !== 3'(DEPTH) || ovf_err !== 1'b0 || wb_id !== 5'd3)
            $display("FAIL b2b_pushpop2: got cnt=%0d ovf=%0b id=%0d expected %0d 0 3", fifo_cnt, ovf_err, wb_id, DEPTH);
        else pass_cnt++;
        for (int j = 3; j <= 6; j++) begin
            total_cnt++;
            if (wb_id !== 5'(j) || wb_data !== rep(32'h2000_0000 + j))
                $display("FAIL b2b_order_%0d: got id=%0d data=%h expected %0d %h", j, wb_id, wb_data, j, rep(32'h2000_0000 + j));
            else pass_cnt++;
            @(negedge clk);
        end
        wb_rdy = 1'b0;
        total_cnt++;
        if (fifo_cnt !== 3'd0 || ovf_err !== 1'b0)
            $display("FAIL b2b_empty: got cnt=%0d ovf=%0b expected 0 0", fifo_cnt, ovf_err);
        else pass_cnt++;
    endtask

    initial begin
        rst    = 1'b1;
        wb_rdy = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_merge();
        test_mismatch();
`ifdef INTTOINT_WB_MERGE_EN
        test_timeout();
`endif
        test_overflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/int_to_int_wb.md
# int_to_int_wb

Writeback collector directly downstream of the INT-to-INT conversion array. It captures the registered 128-bit result and 7-bit micro-instruction each cycle. When compiled in, it merges a low-half and a high-half 16-bit result for the same SMC into one full-register write. It buffers writes in a small FIFO drained by the register file through a valid/ready handshake, and reports overflow because the converter cannot be back-pressured.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2).
- TIMEOUT, 8: idle cycles a pending low-half result waits for its high-half partner.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- dr_inttoint_d_in  input  128  converter result; lane0 [127:96] … lane3 [31:0].
- cru_inttoint_in  input  7  converter micro-instruction; [6] vld, [4] dst_prec (0 = 16b, 1 = 32b), [0] dst_pos (0 = low, 1 = high).
- smc_id_in  input  5  owning SMC of the current beat.
- wb_rdy  input  1  register file accepts the head entry.
- wb_vld  output  1  FIFO non-empty.
- wb_data  output  128  head entry data.
- wb_mask  output  16  head byte enables; bit 15 = byte [127:120].
- wb_id  output  5  head entry SMC id.
- fifo_cnt  output  $clog2(DEPTH)+1  occupancy.
- ovf_err  output  1  sticky, set when a push is dropped.

## Operation
- Beat: cycle with cru_inttoint_in[6] = 1. Lane mask per lane: dst_prec = 1 gives 4'b1111; dst_prec = 0 with pos 0 gives 4'b0011; dst_prec = 0 with pos 1 gives 4'b1100. The 16-bit mask replicates the lane mask ×4.
- Candidate: beat with dst_prec = 0 and dst_pos = 0.
- Stage register S holds {data, mask, id, is_cand}. States:
  - EMPTY
  - HOLD (non-candidate)
  - WAIT (candidate)
- EMPTY + beat: S <= beat; go to WAIT if the beat is a candidate, else HOLD. Nothing is pushed.
- HOLD, no beat: push S, go to EMPTY.
- HOLD + beat: push S, S <= beat, go to HOLD or WAIT.
- WAIT + matching beat (dst_prec = 0, dst_pos = 1, same smc_id): push merged entry. Merged data is bits [31:16] of each lane from the beat and bits [15:0] from S. Merged mask is 16'hFFFF. Go to EMPTY.
- WAIT + non-matching beat: push S (mask 16'h3333), S <= beat, go to HOLD or WAIT.
- WAIT, no beat: increment idle_cnt. When idle_cnt reaches TIMEOUT, push S and go to EMPTY. idle_cnt clears on every state entry.
- At most one push per cycle.
- FIFO pop on wb_vld && wb_rdy. wb_rdy while empty is ignored.
- Push while full and no pop: entry dropped, ovf_err <= 1, S-state transition proceeds as if pushed.
- Push while full with pop: accepted, count unchanged.
- Head pointer and tail pointer wrap modulo DEPTH.
- ovf_err clears only on rst.

## Timing
- rst = 1 at an edge:
  - S becomes EMPTY.
  - Pointers, fifo_cnt and idle_cnt clear.
  - Storage zeroes, so wb_vld/wb_data/wb_mask/wb_id/fifo_cnt/ovf_err all read 0.
  - An input beat present in the same cycle is discarded.
  - Any mid-merge or pending entry is lost.
- Non-candidate beat sampled at edge E0 enters S. It is pushed at E1, and wb_vld is high after E1 (2-edge latency).
- Merged pair: low half at E0, high half at E1. The merged entry is pushed at E1.
- Timeout: candidate at E0, no further beats. Pushed at edge E0+TIMEOUT.
- Head outputs are combinational from FIFO storage. A pop at edge E exposes the next entry after E.
- Full-to-not-full transitions take effect on the edge of the pop.

## Configuration
- INTTOINT_WB_MERGE_EN defined: WAIT state, merging, and idle_cnt/TIMEOUT logic present as above.
- INTTOINT_WB_MERGE_EN undefined:
  - Candidates are treated as non-candidates (WAIT unreachable), so every beat is pushed alone with its own mask.
  - TIMEOUT is unused.
  - Latency is fixed at 2 edges.

## Test plan
- Reset/idle: rst held 3 cycles with beats active -> all outputs 0. First beat after release (32b, data 128'h1…) appears with wb_vld = 1 and mask 16'hFFFF 2 edges later.
- Merge: beat A 16b pos0 (cru 7'b1000000, lanes 32'h0000_AAAA, id 3), next cycle beat B 16b pos1 (cru 7'b1000001, lanes 32'hBBBB_0000, id 3) -> single entry, lanes 32'hBBBB_AAAA, mask 16'hFFFF, id 3.
- Mismatch/timeout: pos0 id 3 then pos1 id 4 -> two entries, masks 16'h3333 then 16'hCCCC. Lone pos0 with TIMEOUT = 8 -> pushed exactly 8 edges after capture.
- Back-pressure/overflow: wb_rdy = 0, DEPTH + 2 consecutive 32b beats -> fifo_cnt saturates at DEPTH, ovf_err = 1 after the first drop. Raising wb_rdy then drains DEPTH entries in order, and ovf_err stays 1.
- Full push + pop same edge: FIFO full, wb_rdy = 1 during a push -> fifo_cnt stays DEPTH, no ovf_err, order preserved across pointer wrap.
- Macro off: the merge sequence above -> two entries, masks 16'h3333 and 16'hCCCC, each at 2-edge latency.
